// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// The HAZARD_PERF_CNT_EN build option is handled in the interface and top files.
package hazard_pkg;
  typedef enum logic {RUN = 1'b0, MDU_BUSY = 1'b1} state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Wide enough for MDU_LAT-2 with MDU_LAT up to 16.
  localparam int MDU_CNT_W = 4;
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
// HAZARD_PERF_CNT_EN adds the four stall-cause counters.
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) ();
  logic [REG_ADDR_W-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [REG_ADDR_W-1:0] write_reg_e, write_reg_m, write_reg_w;
  logic branch_d, jump_d;
  logic mem_to_reg_e, reg_write_e, mem_to_reg_m, reg_write_m, reg_write_w;
  logic mdu_start_e, mem_req_m, mem_ready_m;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic forward_ad, forward_bd;
  logic [1:0] forward_ae, forward_be;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] load_stall_cnt, branch_stall_cnt, mdu_stall_cnt, mem_stall_cnt;
`endif

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           branch_d, jump_d, mem_to_reg_e, reg_write_e, mem_to_reg_m,
           reg_write_m, reg_write_w, mdu_start_e, mem_req_m, mem_ready_m,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
           flush_w, forward_ad, forward_bd, forward_ae, forward_be
`ifdef HAZARD_PERF_CNT_EN
    , output load_stall_cnt, branch_stall_cnt, mdu_stall_cnt, mem_stall_cnt
`endif
  );

  modport master (
    output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           branch_d, jump_d, mem_to_reg_e, reg_write_e, mem_to_reg_m,
           reg_write_m, reg_write_w, mdu_start_e, mem_req_m, mem_ready_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
           flush_w, forward_ad, forward_bd, forward_ae, forward_be
`ifdef HAZARD_PERF_CNT_EN
    , input load_stall_cnt, branch_stall_cnt, mdu_stall_cnt, mem_stall_cnt
`endif
  );
endinterface

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Single-operand forwarding comparator: picks M over W over the register file.
// Register 0 never forwards.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] wrM,
  input  logic                  regWriteM,
  input  logic [REG_ADDR_W-1:0] wrW,
  input  logic                  regWriteW,
  output logic [1:0]            sel
);
  logic srcLive, hitM, hitW;

  assign srcLive = (src != '0);
  assign hitM    = srcLive && (src == wrM) && regWriteM;
  assign hitW    = srcLive && (src == wrW) && regWriteW;
  assign sel     = hitM ? FWD_M : (hitW ? FWD_W : FWD_RF);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline with MDU and memory-wait stalls.
// HAZARD_PERF_CNT_EN adds saturating per-cause stall counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_LAT     = 4,
  parameter int BRANCH_IN_D = 1,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_unit_if.slave hz
);
  localparam int  NUM_OPS   = 4;
  localparam bit  MDU_MULTI = (MDU_LAT > 1);
  localparam bit  BR_D      = (BRANCH_IN_D != 0);
  localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'((MDU_LAT > 1) ? MDU_LAT - 2 : 0);

  // Operand slots: 0 rs_e, 1 rt_e, 2 rs_d, 3 rt_d. D-stage slots only see M.
  localparam logic [NUM_OPS-1:0] USE_W = 4'b0011;

  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] srcs;
  logic [NUM_OPS-1:0][1:0]            sels;

  assign srcs = {hz.rt_d, hz.rs_d, hz.rt_e, hz.rs_e};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
      .src       (srcs[i]),
      .wrM       (hz.write_reg_m),
      .regWriteM (hz.reg_write_m),
      .wrW       (hz.write_reg_w),
      .regWriteW (hz.reg_write_w & USE_W[i]),
      .sel       (sels[i])
    );
  end

  logic wrELive, wrMLive, eHitsD, mHitsD;
  logic lwStall, brStall, memWait, mduHold;

  assign wrELive = (hz.write_reg_e != '0);
  assign wrMLive = (hz.write_reg_m != '0);
  assign eHitsD  = (hz.write_reg_e == hz.rs_d) || (hz.write_reg_e == hz.rt_d);
  assign mHitsD  = (hz.write_reg_m == hz.rs_d) || (hz.write_reg_m == hz.rt_d);
  assign lwStall = hz.mem_to_reg_e && wrELive && eHitsD;
  assign brStall = BR_D && hz.branch_d &&
                   ((hz.reg_write_e && wrELive && eHitsD) ||
                    (hz.mem_to_reg_m && wrMLive && mHitsD));
  assign memWait = hz.mem_req_m && !hz.mem_ready_m;

  state_e               state, stateNxt;
  logic [MDU_CNT_W-1:0] mduCnt, mduCntNxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      mduCnt <= '0;
    end else begin
      state  <= stateNxt;
      mduCnt <= mduCntNxt;
    end
  end

  // Counter keeps draining under memWait; only the exit waits for memory.
  always_comb begin
    stateNxt  = state;
    mduCntNxt = mduCnt;
    mduHold   = 1'b0;
    case (state)
      RUN: begin
        mduHold = hz.mdu_start_e && MDU_MULTI;
        if (hz.mdu_start_e && MDU_MULTI && !memWait) begin
          stateNxt  = MDU_BUSY;
          mduCntNxt = MDU_LOAD;
        end
      end
      MDU_BUSY: begin
        mduHold = (mduCnt != '0);
        if (mduCnt != '0) mduCntNxt = mduCnt - MDU_CNT_W'(1);
        if (mduCnt == '0 && !memWait) stateNxt = RUN;
      end
      default: stateNxt = RUN;
    endcase
  end

  logic winMem, winMdu, winLd, winBr, stallD;

  assign winMem = memWait;
  assign winMdu = !memWait && mduHold;
  assign winLd  = !memWait && !mduHold && lwStall;
  assign winBr  = !memWait && !mduHold && brStall;
  assign stallD = winMem || winMdu || winLd || winBr;

  // Every output is forced low while reset is held.
  always_comb begin
    hz.stall_f    = rst_n && stallD;
    hz.stall_d    = rst_n && stallD;
    hz.stall_e    = rst_n && (winMem || winMdu);
    hz.stall_m    = rst_n && winMem;
    hz.flush_d    = rst_n && hz.jump_d && !stallD;
    hz.flush_e    = rst_n && (winLd || winBr);
    hz.flush_m    = rst_n && winMdu;
    hz.flush_w    = rst_n && winMem;
    hz.forward_ae = rst_n ? sels[0] : FWD_RF;
    hz.forward_be = rst_n ? sels[1] : FWD_RF;
    hz.forward_ad = rst_n && BR_D && (sels[2] == FWD_M);
    hz.forward_bd = rst_n && BR_D && (sels[3] == FWD_M);
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] ldCnt, brCnt, mduStCnt, memCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldCnt    <= '0;
      brCnt    <= '0;
      mduStCnt <= '0;
      memCnt   <= '0;
    end else begin
      if (winLd  && ldCnt    != '1) ldCnt    <= ldCnt    + CNT_W'(1);
      if (winBr  && brCnt    != '1) brCnt    <= brCnt    + CNT_W'(1);
      if (winMdu && mduStCnt != '1) mduStCnt <= mduStCnt + CNT_W'(1);
      if (winMem && memCnt   != '1) memCnt   <= memCnt   + CNT_W'(1);
    end
  end

  assign hz.load_stall_cnt   = ldCnt;
  assign hz.branch_stall_cnt = brCnt;
  assign hz.mdu_stall_cnt    = mduStCnt;
  assign hz.mem_stall_cnt    = memCnt;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: a default-parameter DUT and a MDU_LAT=1 / BRANCH_IN_D=0 DUT on shared stimulus.
// Counter checks are compiled in with HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
  logic branchD, jumpD, m2rE, rwE, m2rM, rwM, rwW, mduStart, memReq, memReady;

  hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) hm ();
  hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) ha ();

  assign {hm.rs_d, hm.rt_d, hm.rs_e, hm.rt_e} = {rsD, rtD, rsE, rtE};
  assign {ha.rs_d, ha.rt_d, ha.rs_e, ha.rt_e} = {rsD, rtD, rsE, rtE};
  assign {hm.write_reg_e, hm.write_reg_m, hm.write_reg_w} = {wrE, wrM, wrW};
  assign {ha.write_reg_e, ha.write_reg_m, ha.write_reg_w} = {wrE, wrM, wrW};
  assign {hm.branch_d, hm.jump_d, hm.mem_to_reg_e, hm.reg_write_e, hm.mem_to_reg_m,
          hm.reg_write_m, hm.reg_write_w, hm.mdu_start_e, hm.mem_req_m, hm.mem_ready_m} =
         {branchD, jumpD, m2rE, rwE, m2rM, rwM, rwW, mduStart, memReq, memReady};
  assign {ha.branch_d, ha.jump_d, ha.mem_to_reg_e, ha.reg_write_e, ha.mem_to_reg_m,
          ha.reg_write_m, ha.reg_write_w, ha.mdu_start_e, ha.mem_req_m, ha.mem_ready_m} =
         {branchD, jumpD, m2rE, rwE, m2rM, rwM, rwW, mduStart, memReq, memReady};

  hazard_ctrl_unit #(.REG_ADDR_W(5), .MDU_LAT(4), .BRANCH_IN_D(1), .CNT_W(32))
    u_dut (.clk(clk), .rst_n(rst_n), .hz(hm));
  hazard_ctrl_unit #(.REG_ADDR_W(5), .MDU_LAT(1), .BRANCH_IN_D(0), .CNT_W(32))
    u_alt (.clk(clk), .rst_n(rst_n), .hz(ha));

  // {stall f,d,e,m | flush d,e,m,w | fwd ad,bd | fwd ae | fwd be}
  logic [13:0] obsM, obsA;
  assign obsM = {hm.stall_f, hm.stall_d, hm.stall_e, hm.stall_m, hm.flush_d, hm.flush_e,
                 hm.flush_m, hm.flush_w, hm.forward_ad, hm.forward_bd, hm.forward_ae, hm.forward_be};
  assign obsA = {ha.stall_f, ha.stall_d, ha.stall_e, ha.stall_m, ha.flush_d, ha.flush_e,
                 ha.flush_m, ha.flush_w, ha.forward_ad, ha.forward_bd, ha.forward_ae, ha.forward_be};

  function automatic logic [13:0] ev(logic [3:0] s, logic [3:0] f, logic [1:0] fd,
                                     logic [1:0] fae, logic [1:0] fbe);
    return {s, f, fd, fae, fbe};
  endfunction

  localparam logic [13:0] Z    = 14'd0;
  localparam logic [13:0] LD   = {4'b1100, 4'b0100, 6'd0};
  localparam logic [13:0] MDU  = {4'b1110, 4'b0010, 6'd0};
  localparam logic [13:0] MEM  = {4'b1111, 4'b0001, 6'd0};
  localparam logic [13:0] JMP  = {4'b0000, 4'b1000, 6'd0};

  typedef struct {
    string       tag;
    logic [13:0] m;
    logic [13:0] a;
  } exp_t;
  exp_t expQ[$];

  int nChecks = 0;
  int nErrs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are set just after a posedge; outputs compared on the following negedge.
  task automatic step(input string tag, input logic [13:0] em, input logic [13:0] ea);
    exp_t e;
    expQ.push_back('{tag: tag, m: em, a: ea});
    @(negedge clk);
    e = expQ.pop_front();
    chk({e.tag, "/main"}, 32'(obsM), 32'(e.m));
    chk({e.tag, "/alt"},  32'(obsA), 32'(e.a));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {rsD, rtD, rsE, rtE, wrE, wrM, wrW} = '0;
    {branchD, jumpD, m2rE, rwE, m2rM, rwM, rwW, mduStart, memReq, memReady} = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rsE = 5'd3; rtE = 5'd3; wrM = 5'd3; rwM = 1'b1;
    @(posedge clk); #1;
    step("reset0", Z, Z);
    step("reset1", Z, Z);
    rst_n = 1'b1;
    idle();
    step("idle", Z, Z);

    // Forwarding
    rsE = 5'd3; rtE = 5'd3; wrM = 5'd3; rwM = 1'b1; wrW = 5'd3; rwW = 1'b1;
    step("fwd_m_over_w", ev(0, 0, 0, 2'b10, 2'b10), ev(0, 0, 0, 2'b10, 2'b10));
    rsE = 5'd0;
    step("fwd_r0", ev(0, 0, 0, 2'b00, 2'b10), ev(0, 0, 0, 2'b00, 2'b10));
    idle();
    rsE = 5'd4; rtE = 5'd7; wrW = 5'd4; rwW = 1'b1; wrM = 5'd7; rwM = 1'b1; rsD = 5'd7; rtD = 5'd4;
    step("fwd_w_m_d", ev(0, 0, 2'b10, 2'b01, 2'b10), ev(0, 0, 2'b00, 2'b01, 2'b10));
    rwM = 1'b0;
    step("fwd_w_only", ev(0, 0, 0, 2'b01, 2'b00), ev(0, 0, 0, 2'b01, 2'b00));

    // Load-use
    idle();
    m2rE = 1'b1; rwE = 1'b1; wrE = 5'd8; rtE = 5'd8; rsD = 5'd8;
    step("lw_rs", LD, LD);
    idle();
    step("lw_after", Z, Z);
    m2rE = 1'b1; rwE = 1'b1;
    step("lw_r0", Z, Z);
    wrE = 5'd9; rtD = 5'd9;
    step("lw_rt", LD, LD);

    // MDU occupancy
    idle();
    mduStart = 1'b1;
    step("mdu_c1", MDU, Z);
    step("mdu_c2", MDU, Z);
    step("mdu_c3", MDU, Z);
    step("mdu_c4", Z, Z);
    mduStart = 1'b0;
    step("mdu_done", Z, Z);

    // Memory wait while the MDU is busy
    mduStart = 1'b1;
    step("mw_c1", MDU, Z);
    mduStart = 1'b0; memReq = 1'b1; memReady = 1'b0;
    step("mw_w1", MEM, MEM);
    step("mw_w2", MEM, MEM);
    step("mw_w3", MEM, MEM);
    memReady = 1'b1;
    step("mw_ready", Z, Z);
    idle();
    mduStart = 1'b1;
    step("mw_run_c1", MDU, Z);
    mduStart = 1'b0;
    step("mw_run_c2", MDU, Z);
    step("mw_run_c3", MDU, Z);
    step("mw_run_c4", Z, Z);

    // Decode-stage branch
    idle();
    branchD = 1'b1; rsD = 5'd5; wrE = 5'd5; rwE = 1'b1;
    step("br_e", LD, Z);
    rwE = 1'b0;
    step("br_e_nowr", Z, Z);
    idle();
    branchD = 1'b1; rtD = 5'd6; wrM = 5'd6; m2rM = 1'b1;
    step("br_m_load", LD, Z);
    rwM = 1'b1;
    step("br_m_fwd", ev(4'b1100, 4'b0100, 2'b01, 0, 0), Z);
    idle();
    branchD = 1'b1; rwE = 1'b1;
    step("br_r0", Z, Z);

    // Jump flush and priority
    idle();
    jumpD = 1'b1;
    step("jump", JMP, JMP);
    m2rE = 1'b1; wrE = 5'd8; rsD = 5'd8;
    step("jump_lw", LD, LD);
    memReq = 1'b1;
    step("prio_mem_lw", MEM, MEM);
    memReady = 1'b1;
    step("prio_ready", LD, LD);
    memReq = 1'b0; memReady = 1'b0; jumpD = 1'b0; mduStart = 1'b1;
    step("prio_mdu_lw", MDU, LD);
    idle();
    step("prio_mdu_c2", MDU, Z);
    step("prio_mdu_c3", MDU, Z);
    step("prio_mdu_c4", Z, Z);

    // Memory wait holds off MDU entry from RUN
    memReq = 1'b1; mduStart = 1'b1;
    step("mw_run_hold", MEM, MEM);
    memReq = 1'b0;
    step("mw_run_go", MDU, Z);
    mduStart = 1'b0;
    step("mw_run_b2", MDU, Z);
    step("mw_run_b3", MDU, Z);
    step("mw_run_end", Z, Z);

    // Reset mid-MDU (BUSY with count 2)
    mduStart = 1'b1;
    step("rst_mdu_c1", MDU, Z);
    rst_n = 1'b0;
    step("rst_mid", Z, Z);
    rst_n = 1'b1; mduStart = 1'b0;
    step("rst_after", Z, Z);
`ifdef HAZARD_PERF_CNT_EN
    chk("cnt_ld_rst",  hm.load_stall_cnt,   32'd0);
    chk("cnt_br_rst",  hm.branch_stall_cnt, 32'd0);
    chk("cnt_mdu_rst", hm.mdu_stall_cnt,    32'd0);
    chk("cnt_mem_rst", hm.mem_stall_cnt,    32'd0);
`endif

    // Counter scenario
    mduStart = 1'b1;
    step("pc_mdu1", MDU, Z);
    mduStart = 1'b0;
    step("pc_mdu2", MDU, Z);
    step("pc_mdu3", MDU, Z);
    step("pc_mdu4", Z, Z);
    m2rE = 1'b1; wrE = 5'd8; rsD = 5'd8;
    step("pc_lw", LD, LD);
    idle();
    memReq = 1'b1;
    step("pc_mem1", MEM, MEM);
    step("pc_mem2", MEM, MEM);
    idle();
    branchD = 1'b1; rsD = 5'd5; wrE = 5'd5; rwE = 1'b1;
    step("pc_br", LD, Z);
    idle();
    step("pc_idle", Z, Z);
`ifdef HAZARD_PERF_CNT_EN
    chk("cnt_ld",      hm.load_stall_cnt,   32'd1);
    chk("cnt_br",      hm.branch_stall_cnt, 32'd1);
    chk("cnt_mdu",     hm.mdu_stall_cnt,    32'd3);
    chk("cnt_mem",     hm.mem_stall_cnt,    32'd2);
    chk("cnt_alt_br",  ha.branch_stall_cnt, 32'd0);
    chk("cnt_alt_mdu", ha.mdu_stall_cnt,    32'd0);
    chk("cnt_alt_ld",  ha.load_stall_cnt,   32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrs);
    $finish;
  end
endmodule
